// File: rtl/tablet_pkg.sv
// Shared types, constants and BCD helpers for the tablet feeder.
package tablet_pkg;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FEED   = 3'd1,
      S_CHANGE = 3'd2,
      S_DONE   = 3'd3,
      S_FAULT  = 3'd4
   } feeder_state_t;

   localparam int unsigned DROP_DIV_DEFAULT = 50000;
   localparam int unsigned PRESC_W          = 16;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      bcd_digit_t r;
      if (d > 4'd9) begin
         r = 4'd9;
      end else begin
         r = d;
      end
      return r;
   endfunction

   // Two-digit BCD increment that saturates at 99.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] v);
      logic [7:0] r;
      if (v == 8'h99) begin
         r = v;
      end else if (v[3:0] >= 4'd9) begin
         r = {v[7:4] + 4'd1, 4'd0};
      end else begin
         r = {v[7:4], v[3:0] + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/tablet_feeder_if.sv
// Control/status bundle between the line controller (master) and the feeder (slave).
interface tablet_feeder_if;
   import tablet_pkg::*;

   logic       start;
   bcd_digit_t f_num;
   bcd_digit_t l_num;
   bcd_digit_t bt_f_num;
   bcd_digit_t bt_l_num;
   logic       bottle_ack;
   logic       jam;
   logic       tablet;
   logic       bottle_req;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] tab_cnt;
   logic [7:0] bott_cnt;

   modport master (
      output start, f_num, l_num, bt_f_num, bt_l_num, bottle_ack, jam,
      input  tablet, bottle_req, busy, done, fault, tab_cnt, bott_cnt
   );

   modport slave (
      input  start, f_num, l_num, bt_f_num, bt_l_num, bottle_ack, jam,
      output tablet, bottle_req, busy, done, fault, tab_cnt, bott_cnt
   );

endinterface

// File: rtl/bcd_cnt2.sv
// Two-digit BCD counter with synchronous clear and saturating increment.
module bcd_cnt2
   import tablet_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       inc,
   output logic [7:0] value
);

   logic [7:0] value_d;
   logic [7:0] value_q;

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = 8'h00;
      end else if (inc) begin
         value_d = bcd2_inc(value_q);
      end else begin
         value_d = value_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         value_q <= 8'h00;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/tablet_feeder.sv
// Tablet feeder controller: paced drops per bottle, bottle changes per batch.
// Optional jam detection is compiled in with JAM_DETECT_EN.
module tablet_feeder
   import tablet_pkg::*;
#(
   parameter int unsigned DROP_DIV = DROP_DIV_DEFAULT
)
(
   input logic              clk,
   input logic              reset,
   tablet_feeder_if.slave   bus
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DROP_DIV - 1);

   feeder_state_t      state_d, state_q;
   logic [7:0]         per_bottle_d, per_bottle_q;
   logic [7:0]         batch_d, batch_q;
   logic [PRESC_W-1:0] presc_d, presc_q;
   logic [7:0]         set_per_s, set_batch_s;
   logic [7:0]         tab_val_s, bott_val_s;
   logic               tab_clr_s, tab_inc_s, bott_clr_s, bott_inc_s;
   logic               tablet_s;

   assign set_per_s   = {bcd_clamp(bus.f_num), bcd_clamp(bus.l_num)};
   assign set_batch_s = {bcd_clamp(bus.bt_f_num), bcd_clamp(bus.bt_l_num)};

   always_comb begin
      state_d      = state_q;
      per_bottle_d = per_bottle_q;
      batch_d      = batch_q;
      presc_d      = presc_q;
      tab_clr_s    = 1'b0;
      tab_inc_s    = 1'b0;
      bott_clr_s   = 1'b0;
      bott_inc_s   = 1'b0;
      tablet_s     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start && (set_per_s != 8'h00) && (set_batch_s != 8'h00)) begin
               state_d      = S_FEED;
               per_bottle_d = set_per_s;
               batch_d      = set_batch_s;
               presc_d      = '0;
               tab_clr_s    = 1'b1;
               bott_clr_s   = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FEED: begin
`ifdef JAM_DETECT_EN
            if (bus.jam) begin
               state_d = S_FAULT;
            end else
`endif
            if (bus.start) begin
               if (presc_q == PRESC_LAST) begin
                  tablet_s  = 1'b1;
                  tab_inc_s = 1'b1;
                  presc_d   = '0;
                  // Compare the post-increment count so CHANGE starts right after the last drop.
                  if (bcd2_inc(tab_val_s) == per_bottle_q) begin
                     state_d = S_CHANGE;
                  end else begin
                     state_d = S_FEED;
                  end
               end else begin
                  presc_d = presc_q + PRESC_W'(1);
               end
            end else begin
               presc_d = presc_q;
            end
         end
         S_CHANGE: begin
            if (bus.bottle_ack) begin
               bott_inc_s = 1'b1;
               if (bcd2_inc(bott_val_s) == batch_q) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_FEED;
                  tab_clr_s = 1'b1;
                  presc_d   = '0;
               end
            end else begin
               state_d = S_CHANGE;
            end
         end
         S_DONE: begin
            if (!bus.start) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
`ifdef JAM_DETECT_EN
         S_FAULT: state_d = S_FAULT;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         per_bottle_q <= 8'h00;
         batch_q      <= 8'h00;
         presc_q      <= '0;
      end else begin
         state_q      <= state_d;
         per_bottle_q <= per_bottle_d;
         batch_q      <= batch_d;
         presc_q      <= presc_d;
      end
   end

   bcd_cnt2 u_tab_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (tab_clr_s),
      .inc   (tab_inc_s),
      .value (tab_val_s)
   );

   bcd_cnt2 u_bott_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (bott_clr_s),
      .inc   (bott_inc_s),
      .value (bott_val_s)
   );

   // The drop pulse is combinational so a jam or pause in the drop cycle can cancel it.
   assign bus.tablet     = tablet_s;
   assign bus.bottle_req = (state_q == S_CHANGE);
   assign bus.busy       = (state_q == S_FEED) || (state_q == S_CHANGE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.tab_cnt    = tab_val_s;
   assign bus.bott_cnt   = bott_val_s;
`ifdef JAM_DETECT_EN
   assign bus.fault      = (state_q == S_FAULT);
`else
   logic jam_unused;
   assign jam_unused     = bus.jam;
   assign bus.fault      = 1'b0;
`endif

endmodule

// File: tb/tb_tablet_feeder.sv
// Bench for tablet_feeder (DROP_DIV=4): vector table, corner sequences, random run vs. reference model.
module tb_tablet_feeder;

   localparam int DIV = 4;
`ifdef JAM_DETECT_EN
   localparam bit JAM_EN = 1'b1;
`else
   localparam bit JAM_EN = 1'b0;
`endif

   typedef enum int {M_IDLE, M_FEED, M_CHANGE, M_DONE, M_FAULT} mstate_t;

   typedef struct {
      logic [3:0] f;
      logic [3:0] l;
      logic [3:0] bf;
      logic [3:0] bl;
      int         exp_pulses;
      logic [7:0] exp_tab;
      logic [7:0] exp_bott;
      bit         exp_done;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   pulses;
   int   cyc;
   int   last_pulse;

   mstate_t m_st;
   int      m_per, m_bat, m_presc, m_tabs, m_bots;

   tablet_feeder_if bus ();

   tablet_feeder #(.DROP_DIV(DIV)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int clampd(input logic [3:0] d);
      return (d > 4'd9) ? 9 : int'(d);
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      logic [3:0] t, o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_outputs();
      logic [20:0] act, exp;
      logic        exp_tab_pulse;
      exp_tab_pulse = (m_st == M_FEED) && bus.start && !(JAM_EN && bus.jam) && (m_presc == DIV - 1);
      act = {bus.tablet, bus.bottle_req, bus.busy, bus.done, bus.fault, bus.tab_cnt, bus.bott_cnt};
      exp = {exp_tab_pulse, m_st == M_CHANGE, (m_st == M_FEED) || (m_st == M_CHANGE),
             m_st == M_DONE, m_st == M_FAULT, to_bcd(m_tabs), to_bcd(m_bots)};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 20)
            $display("FAIL model_cycle: outputs %h, expected %h (cycle %0d)", act, exp, cyc);
      end
      if (bus.tablet === 1'b1) begin
         pulses++;
         last_pulse = cyc;
      end
      cyc++;
   endtask

   // Reference behaviour applied at each rising edge using the inputs held across it.
   task automatic model_step();
      int p, b;
      if (!rst_n) begin
         m_st = M_IDLE; m_per = 0; m_bat = 0; m_presc = 0; m_tabs = 0; m_bots = 0;
      end else begin
         case (m_st)
            M_IDLE: begin
               p = clampd(bus.f_num) * 10 + clampd(bus.l_num);
               b = clampd(bus.bt_f_num) * 10 + clampd(bus.bt_l_num);
               if (bus.start && p != 0 && b != 0) begin
                  m_st = M_FEED; m_per = p; m_bat = b; m_presc = 0; m_tabs = 0; m_bots = 0;
               end
            end
            M_FEED: begin
               if (JAM_EN && bus.jam) m_st = M_FAULT;
               else if (bus.start) begin
                  if (m_presc == DIV - 1) begin
                     m_presc = 0;
                     m_tabs++;
                     if (m_tabs == m_per) m_st = M_CHANGE;
                  end else m_presc++;
               end
            end
            M_CHANGE: begin
               if (bus.bottle_ack) begin
                  m_bots++;
                  if (m_bots == m_bat) m_st = M_DONE;
                  else begin m_tabs = 0; m_presc = 0; m_st = M_FEED; end
               end
            end
            M_DONE: if (!bus.start) m_st = M_IDLE;
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_outputs();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_cfg(input logic [3:0] f, input logic [3:0] l, input logic [3:0] bf, input logic [3:0] bl);
      bus.f_num = f; bus.l_num = l; bus.bt_f_num = bf; bus.bt_l_num = bl;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; bus.start = 1'b0; bus.bottle_ack = 1'b0; bus.jam = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_pulse(input string nm);
      int p0;
      p0 = pulses;
      for (int k = 0; k < 200 && pulses == p0; k++) tick();
      chk({nm, "_pulse_seen"}, 32'(pulses != p0), 32'd1);
   endtask

   task automatic wait_req(input string nm);
      for (int k = 0; k < 400 && bus.bottle_req !== 1'b1; k++) tick();
      chk({nm, "_req_seen"}, 32'(bus.bottle_req), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      do_reset();
      set_cfg(v.f, v.l, v.bf, v.bl);
      bus.start = 1'b1;
      pulses = 0;
      for (int k = 0; k < 1500 && bus.done !== 1'b1; k++) begin
         tick();
         if (bus.busy === 1'b1) set_cfg(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
         bus.bottle_ack = bus.bottle_req;
      end
      chk($sformatf("vec%0d_done", idx), 32'(bus.done), 32'(v.exp_done));
      chk($sformatf("vec%0d_pulses", idx), 32'(pulses), 32'(v.exp_pulses));
      chk($sformatf("vec%0d_tab", idx), 32'(bus.tab_cnt), 32'(v.exp_tab));
      chk($sformatf("vec%0d_bott", idx), 32'(bus.bott_cnt), 32'(v.exp_bott));
      bus.start = 1'b0; bus.bottle_ack = 1'b0;
      tick(); tick();
   endtask

   vec_t vecs[7];

   initial begin
      int t1, t2, p_before;
      n_tests = 0; n_fail = 0; pulses = 0; cyc = 0; last_pulse = 0;
      m_st = M_IDLE; m_per = 0; m_bat = 0; m_presc = 0; m_tabs = 0; m_bots = 0;
      rst_n = 1'b0; bus.start = 1'b0; bus.bottle_ack = 1'b0; bus.jam = 1'b0;
      set_cfg(4'd0, 4'd0, 4'd0, 4'd0);

      vecs[0] = '{4'd0, 4'd3, 4'd0, 4'd2, 6, 8'h03, 8'h02, 1'b1};
      vecs[1] = '{4'd1, 4'd2, 4'd0, 4'd1, 12, 8'h12, 8'h01, 1'b1};
      vecs[2] = '{4'd0, 4'd15, 4'd0, 4'd1, 9, 8'h09, 8'h01, 1'b1};
      vecs[3] = '{4'd0, 4'd1, 4'd1, 4'd0, 10, 8'h01, 8'h10, 1'b1};
      vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd1, 0, 8'h00, 8'h00, 1'b0};
      vecs[5] = '{4'd12, 4'd9, 4'd0, 4'd1, 99, 8'h99, 8'h01, 1'b1};
      vecs[6] = '{4'd0, 4'd1, 4'd9, 4'd9, 99, 8'h01, 8'h99, 1'b1};

      @(posedge clk); #1;
      chk("reset_outputs", 32'({bus.tablet, bus.bottle_req, bus.busy, bus.done, bus.fault,
                                bus.tab_cnt, bus.bott_cnt}), 32'd0);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Pause of two cycles mid-interval stretches that interval by two.
      do_reset();
      set_cfg(4'd0, 4'd5, 4'd0, 4'd1);
      bus.start = 1'b1;
      wait_pulse("pause_p1");
      t1 = last_pulse;
      wait_pulse("pause_p2");
      t2 = last_pulse;
      chk("pause_normal_interval", 32'(t2 - t1), 32'(DIV));
      tick();
      bus.start = 1'b0; tick(); tick();
      bus.start = 1'b1;
      wait_pulse("pause_p3");
      chk("pause_stretched_interval", 32'(last_pulse - t2), 32'(DIV + 2));

      // BCD tens carry across a 12-tablet bottle.
      do_reset();
      set_cfg(4'd1, 4'd2, 4'd0, 4'd1);
      bus.start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         wait_pulse("seq");
         chk($sformatf("tab_seq_%0d", i), 32'(bus.tab_cnt), 32'(to_bcd(i)));
      end
      chk("req_after_12", 32'(bus.bottle_req), 32'd1);

      // Acknowledge held high throughout: one bottle counted per change.
      do_reset();
      bus.bottle_ack = 1'b1;
      set_cfg(4'd0, 4'd2, 4'd0, 4'd3);
      bus.start = 1'b1;
      wait_req("ackhi");
      tick();
      chk("ackhi_bott_after_change", 32'(bus.bott_cnt), 32'h01);
      chk("ackhi_req_dropped", 32'(bus.bottle_req), 32'd0);
      tick(); tick(); tick();
      chk("ackhi_bott_in_feed", 32'(bus.bott_cnt), 32'h01);
      for (int k = 0; k < 200 && bus.done !== 1'b1; k++) tick();
      chk("ackhi_bott_final", 32'(bus.bott_cnt), 32'h03);
      bus.start = 1'b0; bus.bottle_ack = 1'b0; tick();

      // Reset asserted while waiting for a bottle.
      do_reset();
      set_cfg(4'd0, 4'd1, 4'd0, 4'd2);
      bus.start = 1'b1;
      wait_req("rstchg");
      tick();
      chk("rstchg_still_req", 32'(bus.bottle_req), 32'd1);
      rst_n = 1'b0;
      tick();
      chk("rstchg_outputs", 32'({bus.tablet, bus.bottle_req, bus.busy, bus.done, bus.fault,
                                 bus.tab_cnt, bus.bott_cnt}), 32'd0);
      rst_n = 1'b1; bus.start = 1'b0; tick();

      // Jam raised exactly in a drop cycle.
      do_reset();
      set_cfg(4'd0, 4'd5, 4'd0, 4'd1);
      bus.start = 1'b1;
      wait_pulse("jam_p1");
      tick(); tick(); tick();
      bus.jam = 1'b1;
      p_before = pulses;
      tick();
      bus.jam = 1'b0;
`ifdef JAM_DETECT_EN
      chk("jam_pulse_suppressed", 32'(pulses), 32'(p_before));
      chk("jam_fault", 32'(bus.fault), 32'd1);
      chk("jam_busy", 32'(bus.busy), 32'd0);
      tick(); tick(); tick(); tick(); tick();
      chk("jam_fault_sticky", 32'(bus.fault), 32'd1);
      chk("jam_tab_frozen", 32'(bus.tab_cnt), 32'h01);
`else
      chk("jam_ignored_pulse", 32'(pulses), 32'(p_before + 1));
      chk("jam_ignored_fault", 32'(bus.fault), 32'd0);
`endif

      // Random run against the reference model.
      do_reset();
      for (int k = 0; k < 6000; k++) begin
         rst_n          = ($urandom_range(0, 299) != 0);
         bus.start      = ($urandom_range(0, 9) != 0);
         bus.bottle_ack = ($urandom_range(0, 3) == 0);
         bus.jam        = ($urandom_range(0, 149) == 0);
         set_cfg(($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
                 4'($urandom_range(0, 15)));
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
